mul_div_unit: RTL

- Iterative, multi-cycle RV-M arithmetic unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on N-bit operands.
- Sits beside the single-cycle ALU in the execute stage.
- The ALU handles single-cycle ops; this block takes M-extension ops over a valid/ready handshake.
- Radix-2 engine processes one bit per cycle. RISC-V special cases (divide-by-zero, signed overflow) are resolved without iterating.

---
 rtl/mul_div_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative radix-2 RV-M multiply/divide unit. Shift-add
//                multiply and restoring divide on operand magnitudes, one
//                bit per cycle, followed by a one-cycle sign-fix stage.
//                Divide-by-zero and signed overflow bypass the iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] dataA,
  input  logic [N-1:0] dataB,
  input  logic         kill,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         Zero,
  output logic         Negative
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] C_MIN  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] C_ONES = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [N-1:0]    mcand_q;     // multiplicand magnitude or divisor magnitude
  logic [2*N-1:0]  prod_q;      // product; low half doubles as dividend/quotient
  logic [N:0]      rem_q;       // partial remainder
  logic [CW-1:0]   cnt_q;
  logic            neg_res_q;   // product / quotient must be negated
  logic            neg_rem_q;   // remainder must be negated (dataA negative)
  logic [N-1:0]    result_q;
  logic            zero_q;
  logic            negf_q;

  // Operand decode at the accept point
  logic            is_div_d;
  logic            a_signed_d;
  logic            b_signed_d;
  logic            a_neg_d;
  logic            b_neg_d;
  logic [N-1:0]    a_mag_d;
  logic [N-1:0]    b_mag_d;
  logic            dbz_d;
  logic            ovf_d;
  logic [N-1:0]    fast_result_d;

  // Iteration and fix-up datapath
  logic [N:0]      mul_sum_d;
  logic [2*N-1:0]  mul_step_d;
  logic [N+1:0]    div_shift_d;
  logic [N+1:0]    div_diff_d;
  logic            div_ok_d;
  logic [N:0]      rem_step_d;
  logic [N-1:0]    quo_step_d;
  logic [2*N-1:0]  prod_signed_d;
  logic [N-1:0]    quo_fix_d;
  logic [N-1:0]    rem_fix_d;
  logic [N-1:0]    fix_result_d;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign Zero      = zero_q;
  assign Negative  = negf_q;

  // Decode signedness, magnitudes and the special cases of the incoming op
  always_comb begin
    is_div_d   = op[2];
    // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed
    a_signed_d = is_div_d ? ~op[0] : (op[1:0] != 2'b11);
    b_signed_d = is_div_d ? ~op[0] : ~op[1];
    a_neg_d    = a_signed_d & dataA[N-1];
    b_neg_d    = b_signed_d & dataB[N-1];
    a_mag_d    = a_neg_d ? -dataA : dataA;
    b_mag_d    = b_neg_d ? -dataB : dataB;
    dbz_d      = is_div_d && (dataB == '0);
    ovf_d      = is_div_d && !op[0] && (dataA == C_MIN) && (dataB == C_ONES);
    if (op[1]) begin
      fast_result_d = dbz_d ? dataA : '0;
    end else begin
      fast_result_d = dbz_d ? C_ONES : C_MIN;
    end
  end

  // One radix-2 step of each engine plus the sign-fix/output select
  always_comb begin
    mul_sum_d   = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_step_d  = {mul_sum_d, prod_q[N-1:1]};

    div_shift_d = {rem_q, prod_q[N-1]};
    div_diff_d  = div_shift_d - {2'b00, mcand_q};
    div_ok_d    = ~div_diff_d[N+1];
    rem_step_d  = div_ok_d ? div_diff_d[N:0] : div_shift_d[N:0];
    quo_step_d  = {prod_q[N-2:0], div_ok_d};

    prod_signed_d = neg_res_q ? -prod_q : prod_q;
    quo_fix_d     = neg_res_q ? -prod_q[N-1:0] : prod_q[N-1:0];
    rem_fix_d     = neg_rem_q ? -rem_q[N-1:0] : rem_q[N-1:0];

    case (op_q)
      3'b000:                 fix_result_d = prod_signed_d[N-1:0];
      3'b001, 3'b010, 3'b011: fix_result_d = prod_signed_d[2*N-1:N];
      3'b100, 3'b101:         fix_result_d = quo_fix_d;
      default:                fix_result_d = rem_fix_d;
    endcase
  end

  // Control FSM with registered datapath and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      negf_q    <= 1'b0;
    end else if (kill && (state_q != S_IDLE)) begin
      // Flush: abandon the op but leave the last result visible
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && !kill) begin
            op_q      <= op;
            neg_res_q <= a_neg_d ^ b_neg_d;
            neg_rem_q <= a_neg_d;
            cnt_q     <= '0;
            rem_q     <= '0;
            if (dbz_d || ovf_d) begin
              result_q <= fast_result_d;
              zero_q   <= (fast_result_d == '0);
              negf_q   <= fast_result_d[N-1];
              state_q  <= S_DONE;
            end else begin
              if (is_div_d) begin
                mcand_q <= b_mag_d;
                prod_q  <= {{N{1'b0}}, a_mag_d};
              end else begin
                mcand_q <= a_mag_d;
                prod_q  <= {{N{1'b0}}, b_mag_d};
              end
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            rem_q  <= rem_step_d;
            prod_q <= {prod_q[2*N-1:N], quo_step_d};
          end else begin
            prod_q <= mul_step_d;
          end
          if (cnt_q == CW'(N - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          result_q <= fix_result_d;
          zero_q   <= (fix_result_d == '0);
          negf_q   <= fix_result_d[N-1];
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
